// File: rtl/hazard_control_unit.sv
// hazard_control_unit: load-use / multiply stall and branch flush control for the 5-stage pipeline,
// with branch latching across stalls and a saturating stall-cycle counter.
module hazard_control_unit #(
    parameter int REG_ADDR_W      = 5,
    parameter int MUL_LATENCY     = 3,
    parameter int BR_FLUSH_CYCLES = 1,
    parameter int PERF_W          = 16
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [1:0]            Branch,
    input  logic                  IDEXMemRead,
    input  logic [REG_ADDR_W-1:0] IDEXRt,
    input  logic [REG_ADDR_W-1:0] IFIDRs,
    input  logic [REG_ADDR_W-1:0] IFIDRt,
    input  logic                  IFIDUsesRs,
    input  logic                  IFIDUsesRt,
    input  logic                  MulStart,
    output logic                  PCWrite,
    output logic                  IFIDWrite,
    output logic                  IFIDFlush,
    output logic                  IDEXFlush,
    output logic                  Busy,
    output logic [PERF_W-1:0]     StallCount
);
    localparam int MAX_CNT = MUL_LATENCY > BR_FLUSH_CYCLES ? MUL_LATENCY : BR_FLUSH_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    typedef enum logic [1:0] {IDLE, MUL_STALL, BR_FLUSH} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
    logic              load_use, br, stall, flush;

    assign br       = Branch != 2'b00;
    assign load_use = IDEXMemRead && IDEXRt != '0 &&
                      ((IDEXRt == IFIDRs && IFIDUsesRs) || (IDEXRt == IFIDRt && IFIDUsesRt));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Stall wins over flush; a branch seen while stalling is parked in pend_q.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_d      = (stall && br) || (pend_q && !flush);
        stall_cnt_d = (stall && stall_cnt_q != '1) ? stall_cnt_q + PERF_W'(1) : stall_cnt_q;
        case (state_q)
            IDLE: begin
                if (MulStart && MUL_LATENCY > 1) begin
                    state_d = MUL_STALL;
                    cnt_d   = CNT_W'(MUL_LATENCY - 2);
                end else if (flush && BR_FLUSH_CYCLES > 1) begin
                    state_d = BR_FLUSH;
                    cnt_d   = CNT_W'(BR_FLUSH_CYCLES - 2);
                end
            end
            default: begin
                state_d = cnt_q == '0 ? IDLE : state_q;
                cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - CNT_W'(1);
            end
        endcase
    end

    always_comb begin
        stall      = state_q == MUL_STALL || (state_q == IDLE && (MulStart || load_use));
        flush      = state_q == BR_FLUSH ||
                     (state_q == IDLE && !MulStart && !load_use && (pend_q || br));
        PCWrite    = !stall;
        IFIDWrite  = !stall;
        IFIDFlush  = flush;
        IDEXFlush  = stall || flush;
        Busy       = state_q != IDLE || pend_q;
        StallCount = stall_cnt_q;
    end
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: directed checks of two hazard unit configurations driven by shared inputs
// (a: BR_FLUSH_CYCLES=2, PERF_W=16; b: BR_FLUSH_CYCLES=1, PERF_W=4).
module tb_hazard_control_unit;
    logic       Clk = 1'b0, Reset = 1'b1;
    logic [1:0] Branch = '0;
    logic       IDEXMemRead = 1'b0, IFIDUsesRs = 1'b0, IFIDUsesRt = 1'b0, MulStart = 1'b0;
    logic [4:0] IDEXRt = '0, IFIDRs = '0, IFIDRt = '0;
    logic        a_pc, a_ifw, a_iff, a_idf, a_busy;
    logic [15:0] a_cnt;
    logic        b_pc, b_ifw, b_iff, b_idf, b_busy;
    logic [3:0]  b_cnt;
    int errors = 0, checks = 0;

    always #5 Clk = ~Clk;

    hazard_control_unit #(.MUL_LATENCY(3), .BR_FLUSH_CYCLES(2), .PERF_W(16)) dut_a (
        .Clk(Clk), .Reset(Reset), .Branch(Branch), .IDEXMemRead(IDEXMemRead), .IDEXRt(IDEXRt),
        .IFIDRs(IFIDRs), .IFIDRt(IFIDRt), .IFIDUsesRs(IFIDUsesRs), .IFIDUsesRt(IFIDUsesRt),
        .MulStart(MulStart), .PCWrite(a_pc), .IFIDWrite(a_ifw), .IFIDFlush(a_iff),
        .IDEXFlush(a_idf), .Busy(a_busy), .StallCount(a_cnt));

    hazard_control_unit #(.MUL_LATENCY(3), .BR_FLUSH_CYCLES(1), .PERF_W(4)) dut_b (
        .Clk(Clk), .Reset(Reset), .Branch(Branch), .IDEXMemRead(IDEXMemRead), .IDEXRt(IDEXRt),
        .IFIDRs(IFIDRs), .IFIDRt(IFIDRt), .IFIDUsesRs(IFIDUsesRs), .IFIDUsesRt(IFIDUsesRt),
        .MulStart(MulStart), .PCWrite(b_pc), .IFIDWrite(b_ifw), .IFIDFlush(b_iff),
        .IDEXFlush(b_idf), .Busy(b_busy), .StallCount(b_cnt));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush}
    task automatic outs_a(input string tag, input logic [3:0] exp);
        chk({tag, "_a"}, {28'd0, a_pc, a_ifw, a_iff, a_idf}, {28'd0, exp});
    endtask

    task automatic outs_b(input string tag, input logic [3:0] exp);
        chk({tag, "_b"}, {28'd0, b_pc, b_ifw, b_iff, b_idf}, {28'd0, exp});
    endtask

    task automatic cyc;
        @(posedge Clk);
        @(negedge Clk);
        #1;
    endtask

    task automatic clear_in;
        Branch = '0; IDEXMemRead = 0; IDEXRt = '0; IFIDRs = '0; IFIDRt = '0;
        IFIDUsesRs = 0; IFIDUsesRt = 0; MulStart = 0;
    endtask

    initial begin
        #1;
        outs_a("reset", 4'b1100);
        chk("reset_busy", a_busy, 0);
        chk("reset_cnt", a_cnt, 0);
        cyc;
        Reset = 0;
        #1;
        // load-use on rs
        IDEXMemRead = 1; IDEXRt = 8; IFIDRs = 8; IFIDUsesRs = 1;
        #1;
        outs_a("lu_rs", 4'b0001);
        cyc;
        clear_in;
        #1;
        outs_a("lu_after", 4'b1100);
        chk("lu_cnt_a", a_cnt, 1);
        chk("lu_cnt_b", b_cnt, 1);
        // register 0 never hazards
        IDEXMemRead = 1; IDEXRt = 0; IFIDRs = 0; IFIDUsesRs = 1;
        #1;
        outs_a("r0", 4'b1100);
        // rs match but rs unused, then rt match used
        IDEXRt = 5; IFIDRs = 5; IFIDUsesRs = 0;
        #1;
        outs_a("rs_unused", 4'b1100);
        IFIDRt = 5; IFIDUsesRt = 1;
        #1;
        outs_a("lu_rt", 4'b0001);
        IDEXMemRead = 0;
        #1;
        outs_a("no_load", 4'b1100);
        IDEXMemRead = 1;
        cyc;
        clear_in;
        #1;
        chk("lu_rt_cnt", a_cnt, 2);
        // multiply: 3 stall cycles
        MulStart = 1;
        #1;
        outs_a("mul0", 4'b0001);
        chk("mul0_busy", a_busy, 0);
        cyc;
        MulStart = 0;
        #1;
        outs_a("mul1", 4'b0001);
        chk("mul1_busy", a_busy, 1);
        cyc;
        outs_a("mul2", 4'b0001);
        chk("mul2_busy", a_busy, 1);
        cyc;
        outs_a("mul_done", 4'b1100);
        chk("mul_done_busy", a_busy, 0);
        chk("mul_cnt", a_cnt, 5);
        // taken branch in IDLE
        Branch = 2'b01;
        #1;
        outs_a("br0", 4'b1111);
        outs_b("br0", 4'b1111);
        cyc;
        Branch = 2'b10;
        #1;
        outs_a("br1", 4'b1111);
        chk("br1_busy", a_busy, 1);
        outs_b("br_idle2", 4'b1111);
        cyc;
        Branch = 2'b00;
        #1;
        outs_a("br_done", 4'b1100);
        chk("br_ignored_busy", a_busy, 0);
        outs_b("br_done", 4'b1100);
        // branch during 2nd multiply stall cycle
        MulStart = 1;
        cyc;
        MulStart = 0; Branch = 2'b10;
        #1;
        outs_b("mulbr1", 4'b0001);
        cyc;
        Branch = 2'b00;
        #1;
        outs_b("mulbr2", 4'b0001);
        chk("pend_busy", b_busy, 1);
        cyc;
        outs_b("pend_flush", 4'b1111);
        cyc;
        outs_b("pend_done", 4'b1100);
        chk("pend_done_busy", b_busy, 0);
        chk("mulbr_cnt_b", b_cnt, 8);
        cyc;
        chk("mulbr_cnt_a", a_cnt, 8);
        outs_a("mulbr_settle", 4'b1100);
        // load-use together with branch: stall first, flush next
        IDEXMemRead = 1; IDEXRt = 3; IFIDRs = 3; IFIDUsesRs = 1; Branch = 2'b01;
        #1;
        outs_b("lubr0", 4'b0001);
        cyc;
        clear_in;
        #1;
        outs_b("lubr1", 4'b1111);
        cyc;
        outs_b("lubr2", 4'b1100);
        cyc;
        // reset mid-stall with a pending branch
        MulStart = 1;
        cyc;
        MulStart = 0; Branch = 2'b01;
        cyc;
        Branch = 2'b00;
        #1;
        chk("pre_rst_busy", b_busy, 1);
        Reset = 1;
        #1;
        outs_a("rst_mid", 4'b1100);
        outs_b("rst_mid", 4'b1100);
        chk("rst_busy", b_busy, 0);
        chk("rst_cnt_a", a_cnt, 0);
        cyc;
        Reset = 0;
        #1;
        outs_b("rst_rel", 4'b1100);
        cyc;
        outs_b("rst_noflush", 4'b1100);
        chk("rst_noflush_busy", b_busy, 0);
        // saturation of the 4-bit counter
        IDEXMemRead = 1; IDEXRt = 9; IFIDRt = 9; IFIDUsesRt = 1;
        repeat (20) cyc;
        clear_in;
        #1;
        chk("sat_b", b_cnt, 15);
        chk("nosat_a", a_cnt, 20);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
